// File: rtl/acorn128_pkg.sv
// ---------------------------------------------------------------------------
// acorn128_pkg
// Shared definitions for the streaming ACORN-128 engine:
//   - STATE_W       : width of the ACORN LFSR state (293 bits)
//   - step budgets  : INIT_STEPS, PAD_STEPS, FINAL_STEPS, TAG_BITS
//   - phase_e       : top-level FSM phases
//   - acorn_update  : in-place linear feedback of the six LFSR segments
//   - acorn_ks      : keystream bit from the updated state
//   - acorn_fbk     : nonlinear feedback bit (before the message bit is mixed in)
// ---------------------------------------------------------------------------
package acorn128_pkg;

  localparam int STATE_W     = 293;
  localparam int INIT_STEPS  = 1792;
  localparam int PAD_STEPS   = 256;
  localparam int FINAL_STEPS = 768;
  localparam int TAG_BITS    = 128;

  typedef enum logic [2:0] {
    PH_IDLE    = 3'd0,
    PH_INIT    = 3'd1,
    PH_AD      = 3'd2,
    PH_AD_PAD  = 3'd3,
    PH_MSG     = 3'd4,
    PH_MSG_PAD = 3'd5,
    PH_FINAL   = 3'd6,
    PH_DONE    = 3'd7
  } phase_e;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

  function automatic logic ch3(input logic x, input logic y, input logic z);
    return (x & y) ^ (~x & z);
  endfunction

  // Every segment update reads pre-update values, matching the sequential
  // reference order (each tap is consumed before its own segment changes).
  function automatic logic [STATE_W-1:0] acorn_update(input logic [STATE_W-1:0] s);
    logic [STATE_W-1:0] t;
    t      = s;
    t[289] = s[289] ^ s[235] ^ s[230];
    t[230] = s[230] ^ s[196] ^ s[193];
    t[193] = s[193] ^ s[160] ^ s[154];
    t[154] = s[154] ^ s[111] ^ s[107];
    t[107] = s[107] ^ s[66]  ^ s[61];
    t[61]  = s[61]  ^ s[23]  ^ s[0];
    return t;
  endfunction

  function automatic logic acorn_ks(input logic [STATE_W-1:0] s);
    return s[12] ^ s[154] ^ maj3(s[235], s[61], s[193]) ^ ch3(s[230], s[111], s[66]);
  endfunction

  function automatic logic acorn_fbk(input logic [STATE_W-1:0] s, input logic ks,
                                     input logic ca, input logic cb);
    return s[0] ^ ~s[107] ^ maj3(s[244], s[23], s[160]) ^ (ca & s[196]) ^ (cb & ks);
  endfunction

endpackage

// File: rtl/acorn128_step_dw.sv
// ---------------------------------------------------------------------------
// acorn128_step_dw
// Combinational ACORN-128 datapath performing DW consecutive state-update
// steps. Lane i is step i of the cycle (bit 0 is the oldest step).
// Ports:
//   i_state   [STATE_W]  current state
//   i_m       [DW]       message bit per step (ciphertext bit when decrypting)
//   i_ca      [DW]       ca control per step
//   i_cb      [DW]       cb control per step
//   i_decrypt            1: the fed-back bit is i_m ^ ks (recovered plaintext)
//   o_state   [STATE_W]  state after DW steps
//   o_ks      [DW]       keystream bit of each step
// ---------------------------------------------------------------------------
module acorn128_step_dw
  import acorn128_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [STATE_W-1:0] i_state,
  input  logic [DW-1:0]      i_m,
  input  logic [DW-1:0]      i_ca,
  input  logic [DW-1:0]      i_cb,
  input  logic               i_decrypt,
  output logic [STATE_W-1:0] o_state,
  output logic [DW-1:0]      o_ks
);

  always_comb begin
    logic [STATE_W-1:0] v_s;
    logic               v_ks;
    logic               v_m;
    logic               v_f;
    v_s  = i_state;
    o_ks = '0;
    for (int i = 0; i < DW; i++) begin
      v_s     = acorn_update(v_s);
      v_ks    = acorn_ks(v_s);
      v_m     = i_m[i] ^ (i_decrypt & v_ks);
      v_f     = acorn_fbk(v_s, v_ks, i_ca[i], i_cb[i]);
      v_s     = {v_f ^ v_m, v_s[STATE_W-1:1]};
      o_ks[i] = v_ks;
    end
    o_state = v_s;
  end

endmodule

// File: rtl/acorn128_stream_core.sv
// ---------------------------------------------------------------------------
// acorn128_stream_core
// Streaming ACORN-128 AEAD engine: DW steps per advancing clock, AD and
// message streamed as DW-bit words (bit 0 first), 128-bit tag produced at end.
// Optional build macro: ACORN_TAG_CHECK_EN (tag_ok compares tag_out with
// tag_in on decrypt; without it tag_ok is tied low and tag_in is ignored).
// Ports:
//   clk, rst (async, active low)
//   start_in, encrypt_in, key_in[128], iv_in[128], ad_len, msg_len : job setup
//   in_valid/in_ready/in_data[DW]     : AD words then message words
//   out_valid/out_ready/out_data[DW]  : ciphertext / plaintext words
//   tag_in[128], tag_out[128], tag_ok : tag interface
//   busy_out, ready_out               : status
// ---------------------------------------------------------------------------
module acorn128_stream_core
  import acorn128_pkg::*;
#(
  parameter int DW    = 8,
  parameter int LEN_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_in,
  input  logic                encrypt_in,
  input  logic [127:0]        key_in,
  input  logic [127:0]        iv_in,
  input  logic [LEN_W-1:0]    ad_len,
  input  logic [LEN_W-1:0]    msg_len,
  input  logic                in_valid,
  input  logic [DW-1:0]       in_data,
  output logic                in_ready,
  output logic                out_valid,
  output logic [DW-1:0]       out_data,
  input  logic                out_ready,
  input  logic [127:0]        tag_in,
  output logic [127:0]        tag_out,
  output logic                tag_ok,
  output logic                busy_out,
  output logic                ready_out
);

  localparam int SHIFT = $clog2(DW);

  phase_e                r_phase, w_phase_next;
  logic [STATE_W-1:0]    r_state, w_state_next;
  logic [11:0]           r_cnt;
  logic [127:0]          r_key, r_iv;
  logic                  r_encrypt;
  logic [LEN_W-1:0]      r_ad_left, r_msg_left;
  logic [TAG_BITS-1:0]   r_tag_sr, r_tag_out, w_tag_shift;
  logic                  r_out_valid;
  logic [DW-1:0]         r_out_data;

  logic [DW-1:0]         w_m, w_ca, w_cb, w_ks;
  logic [DW-1:0]         w_init_m, w_pad_m, w_pad_ca;
  logic                  w_decrypt, w_adv, w_beat, w_start, w_fixed, w_last;
  logic [11:0]           w_limit;

  assign w_start  = start_in && (r_phase == PH_IDLE || r_phase == PH_DONE);
  // Single output slot: a new message word is taken only if the slot drains this cycle.
  assign in_ready = (r_phase == PH_AD) ||
                    (r_phase == PH_MSG && (!r_out_valid || out_ready));
  assign w_beat   = in_valid && in_ready;
  assign w_fixed  = (r_phase == PH_INIT) || (r_phase == PH_AD_PAD) ||
                    (r_phase == PH_MSG_PAD) || (r_phase == PH_FINAL);

  always_comb begin
    w_limit = 12'(PAD_STEPS);
    case (r_phase)
      PH_INIT:  w_limit = 12'(INIT_STEPS);
      PH_FINAL: w_limit = 12'(FINAL_STEPS);
      default:  w_limit = 12'(PAD_STEPS);
    endcase
  end
  assign w_last = (r_cnt == w_limit - 12'(DW));

  // Per-lane step index drives the fixed-phase message/control schedules.
  for (genvar gi = 0; gi < DW; gi++) begin : g_lane
    logic [11:0] w_idx;
    assign w_idx = r_cnt + 12'(gi);
    assign w_init_m[gi] = (w_idx < 12'd128) ? r_key[w_idx[6:0]] :
                          (w_idx < 12'd256) ? r_iv[w_idx[6:0]]  :
                          (r_key[w_idx[6:0]] ^ (w_idx == 12'd256));
    assign w_pad_m[gi]  = (w_idx == 12'd0);
    assign w_pad_ca[gi] = (w_idx < 12'd128);
  end

  always_comb begin
    w_m       = '0;
    w_ca      = '1;
    w_cb      = '1;
    w_decrypt = 1'b0;
    w_adv     = 1'b0;
    case (r_phase)
      PH_INIT: begin
        w_m   = w_init_m;
        w_adv = 1'b1;
      end
      PH_AD: begin
        w_m   = in_data;
        w_adv = w_beat;
      end
      PH_AD_PAD: begin
        w_m   = w_pad_m;
        w_ca  = w_pad_ca;
        w_adv = 1'b1;
      end
      PH_MSG: begin
        w_m       = in_data;
        w_cb      = '0;
        w_decrypt = !r_encrypt;
        w_adv     = w_beat;
      end
      PH_MSG_PAD: begin
        w_m   = w_pad_m;
        w_ca  = w_pad_ca;
        w_cb  = '0;
        w_adv = 1'b1;
      end
      PH_FINAL: w_adv = 1'b1;
      default: ;
    endcase
  end

  acorn128_step_dw #(.DW(DW)) u_step (
    .i_state   (r_state),
    .i_m       (w_m),
    .i_ca      (w_ca),
    .i_cb      (w_cb),
    .i_decrypt (w_decrypt),
    .o_state   (w_state_next),
    .o_ks      (w_ks)
  );

  // ---------------- FSM ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_phase <= PH_IDLE;
    else      r_phase <= w_phase_next;
  end

  always_comb begin
    w_phase_next = r_phase;
    case (r_phase)
      PH_IDLE, PH_DONE: if (start_in) w_phase_next = PH_INIT;
      PH_INIT:    if (w_last) w_phase_next = (r_ad_left == '0) ? PH_AD_PAD : PH_AD;
      PH_AD:      if (w_beat && r_ad_left == LEN_W'(1)) w_phase_next = PH_AD_PAD;
      PH_AD_PAD:  if (w_last) w_phase_next = (r_msg_left == '0) ? PH_MSG_PAD : PH_MSG;
      PH_MSG:     if (w_beat && r_msg_left == LEN_W'(1)) w_phase_next = PH_MSG_PAD;
      PH_MSG_PAD: if (w_last) w_phase_next = PH_FINAL;
      PH_FINAL:   if (w_last) w_phase_next = PH_DONE;
      default:    w_phase_next = PH_IDLE;
    endcase
  end

  // ---------------- datapath ----------------
  assign w_tag_shift = {w_ks, r_tag_sr[TAG_BITS-1:DW]};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= '0;
      r_cnt       <= '0;
      r_key       <= '0;
      r_iv        <= '0;
      r_encrypt   <= 1'b0;
      r_ad_left   <= '0;
      r_msg_left  <= '0;
      r_tag_sr    <= '0;
      r_tag_out   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else if (w_start) begin
      r_state     <= '0;
      r_cnt       <= '0;
      r_key       <= key_in;
      r_iv        <= iv_in;
      r_encrypt   <= encrypt_in;
      r_ad_left   <= ad_len >> SHIFT;
      r_msg_left  <= msg_len >> SHIFT;
      r_tag_sr    <= '0;
      r_tag_out   <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
    end else begin
      if (w_adv)   r_state <= w_state_next;
      if (w_fixed) r_cnt   <= w_last ? 12'd0 : r_cnt + 12'(DW);
      if (r_phase == PH_AD && w_beat) r_ad_left <= r_ad_left - LEN_W'(1);
      if (r_phase == PH_MSG && w_beat) begin
        r_msg_left  <= r_msg_left - LEN_W'(1);
        r_out_data  <= in_data ^ w_ks;
        r_out_valid <= 1'b1;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
      // Tag = keystream of the last TAG_BITS FINAL steps; the shift register
      // stays internal so only a complete tag reaches tag_out.
      if (r_phase == PH_FINAL && r_cnt >= 12'(FINAL_STEPS - TAG_BITS)) begin
        r_tag_sr <= w_tag_shift;
        if (w_last) r_tag_out <= w_tag_shift;
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign tag_out   = r_tag_out;
  assign busy_out  = (r_phase != PH_IDLE) && (r_phase != PH_DONE);
  assign ready_out = (r_phase == PH_DONE);

`ifdef ACORN_TAG_CHECK_EN
  assign tag_ok = (r_phase == PH_DONE) && (r_encrypt || (r_tag_out == tag_in));
`else
  logic w_tag_in_unused;
  assign w_tag_in_unused = ^tag_in;
  assign tag_ok          = 1'b0;
`endif

endmodule
